// File: rtl/pslip_accept_sched.sv
// Input-port requester/accepter for a prioritized SLIP scheduler (one instance per input).
// Build option: define ACC_PTR_ALL_ITER_EN to advance round-robin pointers on every accept.
module pslip_accept_sched #(
    parameter int N    = 4,
    parameter int P    = 16,
    parameter int C    = $clog2(P),
    parameter int ITER = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N-1:0]         voq_valid,
    input  logic [N*C-1:0]       voq_pri,
    output logic [N-1:0]         req,
    output logic [N*C-1:0]       req_pri,
    input  logic [N-1:0]         gnt_in,
    input  logic [N*C-1:0]       gnt_pri,
    output logic [N-1:0]         acc,
    output logic                 any_acc,
    output logic                 match_valid,
    output logic [$clog2(N)-1:0] match_dst,
    output logic [N-1:0]         deq,
    output logic                 busy
);
    localparam int NW = $clog2(N);
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, REQ, GNT, ACC, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            matched_q, matched_d;
    logic [NW-1:0]   match_dst_q, match_dst_d;
    logic [NW-1:0]   ptr_q [P];
    logic [NW-1:0]   ptr_d [P];
    logic [N-1:0]    req_q, req_d;
    logic [N*C-1:0]  req_pri_q, req_pri_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N*C-1:0]  gpri_q, gpri_d;
    logic            match_valid_q, match_valid_d;
    logic [N-1:0]    deq_q, deq_d;
    logic            busy_q, busy_d;

    logic [N-1:0]    req_s;
    logic [N*C-1:0]  req_pri_s;
    logic [N-1:0]    eff_s;
    logic [N-1:0]    cand_s;
    logic [C-1:0]    pmax_s;
    logic [NW:0]     sum_s;
    logic [NW-1:0]   pos_s;
    logic [NW-1:0]   win_s;
    logic            win_vld_s;
    logic [NW-1:0]   next_ptr_s;
    logic [N-1:0]    acc_s;
    logic            upd_s;
    logic            done_s;

    // Request vector offered in REQ: VOQ occupancy, priorities masked to zero where empty.
    always_comb begin
        req_s     = matched_q ? {N{1'b0}} : voq_valid;
        req_pri_s = {(N*C){1'b0}};
        for (int n = 0; n < N; n++) begin
            req_pri_s[n*C +: C] = req_s[n] ? voq_pri[n*C +: C] : {C{1'b0}};
        end
    end

    // Accept selection: highest granted priority, then round-robin from that level's pointer.
    always_comb begin
        eff_s     = gnt_q & req_q;
        pmax_s    = {C{1'b0}};
        cand_s    = {N{1'b0}};
        sum_s     = {(NW+1){1'b0}};
        pos_s     = {NW{1'b0}};
        win_s     = {NW{1'b0}};
        win_vld_s = 1'b0;
        for (int n = 0; n < N; n++) begin
            pmax_s = (eff_s[n] && (gpri_q[n*C +: C] > pmax_s)) ? gpri_q[n*C +: C] : pmax_s;
        end
        for (int n = 0; n < N; n++) begin
            cand_s[n] = eff_s[n] && (gpri_q[n*C +: C] == pmax_s);
        end
        for (int k = 0; k < N; k++) begin
            sum_s     = {1'b0, ptr_q[pmax_s]} + (NW+1)'(k);
            pos_s     = (sum_s >= (NW+1)'(N)) ? NW'(sum_s - (NW+1)'(N)) : sum_s[NW-1:0];
            win_s     = (!win_vld_s && cand_s[pos_s]) ? pos_s : win_s;
            win_vld_s = win_vld_s | cand_s[pos_s];
        end
        acc_s      = ((state_q == ACC) && !matched_q && win_vld_s) ? (ONE_N << win_s) : {N{1'b0}};
        next_ptr_s = (win_s == NW'(N-1)) ? {NW{1'b0}} : (win_s + NW'(1));
`ifdef ACC_PTR_ALL_ITER_EN
        upd_s = 1'b1;
`else
        upd_s = (iter_q == {IW{1'b0}});
`endif
    end

    // Round sequencing: next-state and next-value logic for every register.
    always_comb begin
        state_d       = state_q;
        iter_d        = iter_q;
        matched_d     = matched_q;
        match_dst_d   = match_dst_q;
        ptr_d         = ptr_q;
        req_d         = req_q;
        req_pri_d     = req_pri_q;
        gnt_d         = gnt_q;
        gpri_d        = gpri_q;
        match_valid_d = 1'b0;
        deq_d         = {N{1'b0}};
        done_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = REQ;
                    matched_d = 1'b0;
                    iter_d    = {IW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                req_d     = req_s;
                req_pri_d = req_pri_s;
                state_d   = GNT;
            end
            GNT: begin
                gnt_d   = gnt_in;
                gpri_d  = gnt_pri;
                state_d = ACC;
            end
            ACC: begin
                if (acc_s != {N{1'b0}}) begin
                    matched_d      = 1'b1;
                    match_dst_d    = win_s;
                    ptr_d[pmax_s]  = upd_s ? next_ptr_s : ptr_q[pmax_s];
                end else begin
                    matched_d = matched_q;
                end
                done_s = (iter_q == IW'(ITER-1)) || matched_d;
                if (done_s) begin
                    state_d       = DONE;
                    match_valid_d = matched_d;
                    deq_d         = matched_d ? (ONE_N << match_dst_d) : {N{1'b0}};
                end else begin
                    iter_d  = iter_q + IW'(1);
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            iter_q        <= {IW{1'b0}};
            matched_q     <= 1'b0;
            match_dst_q   <= {NW{1'b0}};
            for (int p = 0; p < P; p++) begin
                ptr_q[p] <= {NW{1'b0}};
            end
            req_q         <= {N{1'b0}};
            req_pri_q     <= {(N*C){1'b0}};
            gnt_q         <= {N{1'b0}};
            gpri_q        <= {(N*C){1'b0}};
            match_valid_q <= 1'b0;
            deq_q         <= {N{1'b0}};
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            iter_q        <= iter_d;
            matched_q     <= matched_d;
            match_dst_q   <= match_dst_d;
            ptr_q         <= ptr_d;
            req_q         <= req_d;
            req_pri_q     <= req_pri_d;
            gnt_q         <= gnt_d;
            gpri_q        <= gpri_d;
            match_valid_q <= match_valid_d;
            deq_q         <= deq_d;
            busy_q        <= busy_d;
        end
    end

    assign req         = (state_q == REQ) ? req_s
                       : ((state_q == GNT) ? req_q : {N{1'b0}});
    assign req_pri     = (state_q == REQ) ? req_pri_s
                       : ((state_q == GNT) ? req_pri_q : {(N*C){1'b0}});
    assign acc         = acc_s;
    assign any_acc     = |acc_s;
    assign match_valid = match_valid_q;
    assign match_dst   = match_dst_q;
    assign deq         = deq_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pslip_accept_sched.sv
// Bench for pslip_accept_sched: directed and random scheduling rounds against a round-level model.
module tb_pslip_accept_sched;
    localparam int N    = 4;
    localparam int P    = 16;
    localparam int C    = 4;
    localparam int ITER = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   voq_valid = '0;
    logic [N*C-1:0] voq_pri = '0;
    logic [N-1:0]   req;
    logic [N*C-1:0] req_pri;
    logic [N-1:0]   gnt_in = '0;
    logic [N*C-1:0] gnt_pri = '0;
    logic [N-1:0]   acc;
    logic           any_acc;
    logic           match_valid;
    logic [1:0]     match_dst;
    logic [N-1:0]   deq;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int ptr_m [P];
    int last_dst;

    pslip_accept_sched #(.N(N), .P(P), .C(C), .ITER(ITER)) dut (
        .clk(clk), .reset(reset), .start(start),
        .voq_valid(voq_valid), .voq_pri(voq_pri),
        .req(req), .req_pri(req_pri),
        .gnt_in(gnt_in), .gnt_pri(gnt_pri),
        .acc(acc), .any_acc(any_acc), .match_valid(match_valid),
        .match_dst(match_dst), .deq(deq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pri_of(input logic [N*C-1:0] v, input int n);
        return int'(v[n*C +: C]);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < P; p++) ptr_m[p] = 0;
        last_dst = 0;
    endtask

    // One full round; g0/gp0 are the grants shown in iteration 0, g1/gp1 in iteration 1.
    task automatic do_round(input logic [N-1:0] v, input logic [N*C-1:0] vp,
                            input logic [N-1:0] g0, input logic [N*C-1:0] gp0,
                            input logic [N-1:0] g1, input logic [N*C-1:0] gp1);
        logic [N-1:0]   g, eff, exp_acc;
        logic [N*C-1:0] gp, exp_pri;
        int matched, dst, pmax, win, upd;
        matched = 0;
        dst     = last_dst;
        for (int n = 0; n < N; n++) exp_pri[n*C +: C] = v[n] ? vp[n*C +: C] : 4'd0;
        @(negedge clk);
        start = 1'b1; voq_valid = v; voq_pri = vp;
        #1 chk("idle_busy", busy, 0);
        for (int i = 0; i < ITER; i++) begin
            @(negedge clk);
            start = 1'b0; voq_valid = v; voq_pri = vp;
            gnt_in = N'($urandom); gnt_pri = (N*C)'($urandom);
            #1;
            chk("req_busy", busy, 1);
            chk("req_vec", req, v);
            chk("req_pri", req_pri, exp_pri);
            chk("req_acc", acc, 0);
            g  = (i == 0) ? g0 : g1;
            gp = (i == 0) ? gp0 : gp1;
            @(negedge clk);
            gnt_in = g; gnt_pri = gp; start = 1'b1;
            voq_valid = N'($urandom); voq_pri = (N*C)'($urandom);
            #1;
            chk("gnt_req", req, v);
            chk("gnt_req_pri", req_pri, exp_pri);
            eff = g & v;
            exp_acc = '0;
            if (eff != 0) begin
                pmax = 0;
                for (int n = 0; n < N; n++)
                    if (eff[n] && pri_of(gp, n) > pmax) pmax = pri_of(gp, n);
                win = -1;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (ptr_m[pmax] + k) % N;
                    if (win < 0 && eff[idx] && pri_of(gp, idx) == pmax) win = idx;
                end
`ifdef ACC_PTR_ALL_ITER_EN
                upd = 1;
`else
                upd = (i == 0);
`endif
                if (upd != 0) ptr_m[pmax] = (win + 1) % N;
                exp_acc[win] = 1'b1;
                matched = 1;
                dst = win;
            end
            @(negedge clk);
            start = 1'b0;
            gnt_in = N'($urandom); gnt_pri = (N*C)'($urandom);
            #1;
            chk("acc_vec", acc, exp_acc);
            chk("any_acc", any_acc, (exp_acc != 0));
            chk("acc_no_match_yet", match_valid, 0);
            if (matched != 0) break;
        end
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("done_match_valid", match_valid, matched);
        chk("done_deq", deq, (matched != 0) ? (4'b0001 << dst) : 4'b0000);
        chk("done_match_dst", match_dst, dst);
        chk("done_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("back_idle", busy, 0);
        chk("idle_match_valid", match_valid, 0);
        chk("idle_deq", deq, 0);
        chk("held_match_dst", match_dst, dst);
        last_dst = dst;
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_req_pri", req_pri, 0);
        chk("rst_acc", acc, 0);
        chk("rst_any_acc", any_acc, 0);
        chk("rst_match_valid", match_valid, 0);
        chk("rst_match_dst", match_dst, 0);
        chk("rst_deq", deq, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // all pointers start at 0: lowest index wins a full tie
        do_round(4'b1111, 16'h0000, 4'b1111, 16'h0000, 4'b0000, 16'h0000);
        // equal-priority pair: round-robin at level 3, including wrap back to 0
        do_round(4'b1010, 16'h3030, 4'b1010, 16'h3030, 4'b0000, 16'h0000);
        do_round(4'b1010, 16'h3030, 4'b1010, 16'h3030, 4'b0000, 16'h0000);
        do_round(4'b1010, 16'h3030, 4'b1010, 16'h3030, 4'b0000, 16'h0000);
        // higher priority wins regardless of pointer
        do_round(4'b1111, 16'h1234, 4'b0101, 16'h0902, 4'b0000, 16'h0000);
        // match only in the second iteration
        do_round(4'b1111, 16'h5555, 4'b0000, 16'h0000, 4'b1000, 16'h5000);
        do_round(4'b1111, 16'h5555, 4'b0000, 16'h0000, 4'b0100, 16'h0500);
        do_round(4'b1111, 16'h5555, 4'b1100, 16'h5500, 4'b0000, 16'h0000);
        // grant to a non-requesting output is ignored; no match
        do_round(4'b1011, 16'h7777, 4'b0100, 16'h0F00, 4'b0100, 16'h0F00);
        // empty VOQs
        do_round(4'b0000, 16'hFFFF, 4'b1111, 16'hFFFF, 4'b1111, 16'hFFFF);

        // reset during GNT aborts the round
        @(negedge clk);
        start = 1'b1; voq_valid = 4'b1111; voq_pri = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        gnt_in = 4'b1111; gnt_pri = 16'h2222; reset = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_acc", acc, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req", req, 0);
        chk("abort_match_dst", match_dst, 0);
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("abort_no_match", match_valid, 0);
            chk("abort_no_deq", deq, 0);
        end
        do_round(4'b1111, 16'h0000, 4'b1111, 16'h0000, 4'b0000, 16'h0000);
        do_round(4'b1010, 16'h3030, 4'b1010, 16'h3030, 4'b0000, 16'h0000);

        for (int r = 0; r < 40; r++) begin
            do_round(N'($urandom), (N*C)'($urandom) & 16'h3333,
                     N'($urandom), (N*C)'($urandom) & 16'h3333,
                     N'($urandom), (N*C)'($urandom) & 16'h3333);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
